// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_pkg
// Brief    : Shared types and constants for the bit-serial subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

  localparam int SUB_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-index counter width; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_full_sub.sv
`default_nettype none
// ============================================================================
// Module   : full_sub
// Brief    : One-bit full subtractor, d = a - b - bin with borrow out.
// Revision : 1.0 - initial release
// ============================================================================
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a, or when the bits tie and a borrow ripples in.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial WIDTH-bit subtractor (diff = x - y), LSB first,
//            one bit per clock, start/done handshake, results held.
//            Optional macro SERIAL_SUB_OVF_EN adds the signed-overflow
//            output ovf and its sign-bit latches.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_diff_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_bin;
  logic             r_bout;
  logic             w_d;
  logic             w_bout;

`ifdef SERIAL_SUB_OVF_EN
  logic             r_xs;
  logic             r_ys;
  logic             r_ovf;
`endif

  // Single bit-slice, fed from the LSBs of the operand shift registers.
  full_sub u_full_sub (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .bin  (r_bin),
    .d    (w_d),
    .bout (w_bout)
  );

  // State register; reset takes priority over any start request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic with accept and last-bit strobes for the datapath.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt == c_last) begin
          w_last = 1'b1;
          w_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = BUSY;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: load operands on accept, then shift one bit per BUSY cycle.
  // Results are held outside BUSY, so they survive until the first bit edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr    <= '0;
      r_b_sr    <= '0;
      r_diff_sr <= '0;
      r_cnt     <= '0;
      r_bin     <= 1'b0;
      r_bout    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_xs      <= 1'b0;
      r_ys      <= 1'b0;
      r_ovf     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a_sr <= x;
      r_b_sr <= y;
      r_cnt  <= '0;
      r_bin  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_xs   <= x[WIDTH-1];
      r_ys   <= y[WIDTH-1];
`endif
    end else if (r_state == BUSY) begin
      r_diff_sr <= {w_d, r_diff_sr[WIDTH-1:1]};
      r_a_sr    <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr    <= {1'b0, r_b_sr[WIDTH-1:1]};
      r_bin     <= w_bout;
      r_cnt     <= r_cnt + 1'b1;
      if (w_last) begin
        r_bout <= w_bout;
`ifdef SERIAL_SUB_OVF_EN
        // The bit computed on the last edge becomes the result sign.
        r_ovf  <= (r_xs != r_ys) && (w_d != r_xs);
`endif
      end
    end
  end

  assign busy = (r_state == BUSY);
  assign done = (r_state == DONE);
  assign diff = r_diff_sr;
  assign bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule
`default_nettype wire
